truth_table_extractor: RTL and testbench
========================================

Name: truth_table_extractor

Overview:
Sequential "reader" for the team's combinational minimized-logic blocks. On request it sweeps every input combination of an N-variable function, waits for the function output to settle, and samples it. It assembles the results into a minterm mask and compares that mask with an expected value. It sits beside a combinational function block (e.g. the 4-input f1/f2 style blocks) as a self-check and characterisation engine.

Parameters:
N_VARS, 4, number of function inputs driven; mask width is 2**N_VARS
SETTLE_CYCLES, 1, extra cycles vec_out is held before f_in is sampled (0 allowed)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  scan request, sampled only in IDLE
expected_mask  input  2**N_VARS  reference minterm mask, latched when start is accepted
f_in  input  1  output of the function under test
vec_out  output  N_VARS  input combination driven to the function; bit N_VARS-1 = MSB variable (a), bit 0 = LSB (d)
busy  output  1  scan in progress
done  output  1  one-cycle pulse, scan complete
minterm_mask  output  2**N_VARS  bit i = sampled f_in for vec_out == i
match  output  1  minterm_mask == latched expected_mask, valid from done, held until next accepted start

Behaviour:
- Reset (asynchronous, any state): state=IDLE, vec_out=0, busy=0, done=0, minterm_mask=0, match=0, settle counter=0, expected latch=0. An in-progress scan is abandoned; a new start is required afterwards.
- States: IDLE, HOLD, DONE.
- IDLE: if start=1 at an edge, latch expected_mask, clear minterm_mask, set vec_out=0, busy=1, counter=SETTLE_CYCLES, go to HOLD. Otherwise all outputs hold.
- HOLD, counter>0: decrement the counter; vec_out is unchanged.
- HOLD, counter==0: minterm_mask[vec_out] <= f_in.
  - If vec_out != 2**N_VARS-1: vec_out <= vec_out+1 and counter <= SETTLE_CYCLES.
  - Otherwise: go to DONE. vec_out stays at its maximum value.
- DONE (one cycle): done=1, busy=0, match=(minterm_mask==latched expected). Then go to IDLE, where done=0.
- Timing: each vec_out value is held for SETTLE_CYCLES+1 cycles. The full scan is 2**N_VARS*(SETTLE_CYCLES+1) cycles after the start edge. done is asserted on the cycle after the last sample; with the defaults it is high in cycle 33 after the start edge.
- start while busy or in DONE: ignored; no restart and no effect on the latched expected value.
- start held high continuously: a new scan begins on the first IDLE edge after DONE (back-to-back scans).
- expected_mask changing during a scan: no effect.
- minterm_mask is registered; bits not yet sampled read 0 during a scan. Final mask and match persist in IDLE until the next accepted start.
- vec_out wrap: never wraps during a scan. The next scan restarts it from 0.

Optional Feature:
MINTERM_COUNT_EN. When defined, adds output minterm_count (N_VARS+1 bits):
- reset to 0, cleared on an accepted start
- incremented at each sample where f_in=1
- final value equals popcount(minterm_mask) when done is asserted
When not defined, the port and its counter logic are absent; all other behaviour is identical.

Test Plan:
- Defaults, f_in tied 0, expected 0x0000, pulse start -> done in cycle 33, minterm_mask=0x0000, match=1, busy high for cycles 1-32.
- f_in = vec_out[0] -> minterm_mask=0xAAAA; with expected 0xAAAB -> match=0.
- f_in = b'd' + a'bd + abc' driven from vec_out, expected 0x35A5 -> mask 0x35A5, match=1 (minterm_count=8 with MINTERM_COUNT_EN).
- SETTLE_CYCLES=0, f_in tied 1 -> vec_out advances every cycle, done in cycle 17, mask 0xFFFF.
- Assert rst at cycle 10 of a scan -> all outputs 0 immediately, state IDLE. A restart then completes normally with the correct mask.
- Pulse start again at cycle 5 of a scan and change expected_mask mid-scan -> scan timing unchanged, match computed against the originally latched value.

Source files
------------

// File: rtl/truth_table_extractor.sv
// ============================================================================
// truth_table_extractor
// ----------------------------------------------------------------------------
// Purpose:
//   Sequential reader for a combinational N-variable function. When start is
//   accepted it drives every input combination on vec_out, from 0 up to
//   2**N_VARS-1. Each combination is held for SETTLE_CYCLES+1 cycles, and
//   f_in is sampled in the last of those cycles. The samples build a minterm
//   mask, which is then compared with a reference mask latched at start.
//
// Parameters:
//   N_VARS         number of function inputs (mask width is 2**N_VARS)
//   SETTLE_CYCLES  extra hold cycles before each sample (0 allowed)
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   start          scan request, only honoured in IDLE
//   expected_mask  reference minterm mask, latched on an accepted start
//   f_in           output of the function under test
//   vec_out        combination driven to the function (MSB = variable a)
//   busy           scan in progress
//   done           one-cycle pulse when the scan is complete
//   minterm_mask   bit i = sampled f_in for vec_out == i
//   match          minterm_mask == latched reference, valid from done
//   minterm_count  (MINTERM_COUNT_EN only) number of sampled ones
//
// Optional feature macro: MINTERM_COUNT_EN
// ============================================================================
module truth_table_extractor #(
    parameter int N_VARS        = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [(2**N_VARS)-1:0]   expected_mask,
    input  logic                     f_in,
    output logic [N_VARS-1:0]        vec_out,
    output logic                     busy,
    output logic                     done,
    output logic [(2**N_VARS)-1:0]   minterm_mask,
    output logic                     match
`ifdef MINTERM_COUNT_EN
    ,
    output logic [N_VARS:0]          minterm_count
`endif
);

    // The settle counter needs at least one bit, even when SETTLE_CYCLES is 0.
    localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [N_VARS-1:0] VEC_MAX    = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [N_VARS-1:0]        vec_q, vec_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [(2**N_VARS)-1:0]   mask_q, mask_d;
    logic [(2**N_VARS)-1:0]   exp_q, exp_d;
    logic                     match_q, match_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
`ifdef MINTERM_COUNT_EN
    logic [N_VARS:0]          count_q, count_d;
`endif

    // Next-state logic. match is computed from the mask value that includes
    // the final sample, so it is already valid in the cycle where done is high.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        mask_d  = mask_q;
        exp_d   = exp_q;
        match_d = match_q;
        cnt_d   = cnt_q;
`ifdef MINTERM_COUNT_EN
        count_d = count_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    exp_d   = expected_mask;
                    mask_d  = '0;
                    vec_d   = '0;
                    busy_d  = 1'b1;
                    match_d = 1'b0;
                    cnt_d   = CNT_RELOAD;
`ifdef MINTERM_COUNT_EN
                    count_d = '0;
`endif
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    mask_d[vec_q] = f_in;
`ifdef MINTERM_COUNT_EN
                    count_d = count_q + {{N_VARS{1'b0}}, f_in};
`endif
                    if (vec_q != VEC_MAX) begin
                        vec_d = vec_q + N_VARS'(1);
                        cnt_d = CNT_RELOAD;
                    end else begin
                        // vec_out stays at its maximum; the next scan restarts it.
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        match_d = (mask_d == exp_q);
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers. Reset abandons any scan in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mask_q  <= '0;
            exp_q   <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
`ifdef MINTERM_COUNT_EN
            count_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mask_q  <= mask_d;
            exp_q   <= exp_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
`ifdef MINTERM_COUNT_EN
            count_q <= count_d;
`endif
        end
    end

    assign vec_out      = vec_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign minterm_mask = mask_q;
    assign match        = match_q;
`ifdef MINTERM_COUNT_EN
    assign minterm_count = count_q;
`endif

endmodule

// File: tb/tb_truth_table_extractor.sv
// ============================================================================
// tb_truth_table_extractor
// ----------------------------------------------------------------------------
// Directed bench for truth_table_extractor. Two instances share the clock and
// reset: dut_a uses the default parameters, and dut_b uses SETTLE_CYCLES=0.
// The function under test is modelled here and driven from each instance's
// vec_out.
// ============================================================================
module tb_truth_table_extractor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        start_a = 1'b0, start_b = 1'b0;
    logic [15:0] exp_a = '0, exp_b = '0;
    logic        f_a, f_b;
    logic [3:0]  vec_a, vec_b;
    logic        busy_a, busy_b, done_a, done_b, match_a, match_b;
    logic [15:0] mask_a, mask_b;
`ifdef MINTERM_COUNT_EN
    logic [4:0]  cnt_a, cnt_b;
`endif

    int          fmode = 0;
    bit          sel   = 1'b0;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    // Function modes: 0 = tied 0, 1 = d, 2 = b'd' + a'bd + abc', 3 = tied 1
    function automatic logic fmodel(input int m, input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        case (m)
            1:       return d;
            2:       return (!b && !d) || (!a && b && d) || (a && b && !c);
            3:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign f_a = fmodel(fmode, vec_a);
    assign f_b = fmodel(fmode, vec_b);

    truth_table_extractor dut_a (
        .clk(clk), .rst(rst), .start(start_a), .expected_mask(exp_a), .f_in(f_a),
        .vec_out(vec_a), .busy(busy_a), .done(done_a), .minterm_mask(mask_a),
        .match(match_a)
`ifdef MINTERM_COUNT_EN
        , .minterm_count(cnt_a)
`endif
    );

    truth_table_extractor #(.N_VARS(4), .SETTLE_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .expected_mask(exp_b), .f_in(f_b),
        .vec_out(vec_b), .busy(busy_b), .done(done_b), .minterm_mask(mask_b),
        .match(match_b)
`ifdef MINTERM_COUNT_EN
        , .minterm_count(cnt_b)
`endif
    );

    // Views of the instance currently selected by sel
    logic        o_busy, o_done, o_match;
    logic [15:0] o_mask;
    logic [3:0]  o_vec;
    assign o_busy  = sel ? busy_b  : busy_a;
    assign o_done  = sel ? done_b  : done_a;
    assign o_match = sel ? match_b : match_a;
    assign o_mask  = sel ? mask_b  : mask_a;
    assign o_vec   = sel ? vec_b   : vec_a;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    task automatic setStart(input logic v);
        if (sel) start_b = v; else start_a = v;
    endtask

    // Runs one scan on the selected instance. It checks the done cycle, the
    // busy length, the mask, match, the persistence after done, and the count.
    // If restart is set, start is pulsed again and the reference is changed
    // during the scan.
    task automatic applyStimulus(input string tag, input bit which, input int m,
                                 input logic [15:0] ref_mask, input bit restart,
                                 input int want_done, input logic [15:0] want_mask,
                                 input bit want_match, input int want_count);
        int done_at  = -1;
        int busy_cnt = 0;
        sel   = which;
        fmode = m;
        @(negedge clk);
        if (which) exp_b = ref_mask; else exp_a = ref_mask;
        setStart(1'b1);
        @(posedge clk);
        #1;
        setStart(1'b0);
        if (o_busy) busy_cnt++;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (restart && i == 5) begin
                setStart(1'b1);
                if (which) exp_b = 16'h1234; else exp_a = 16'h1234;
            end
            if (restart && i == 6) setStart(1'b0);
            if (o_done) begin
                done_at = i;
                break;
            end
            if (o_busy) busy_cnt++;
        end
        checkOutput({tag, "_done_cycle"}, 32'(done_at + 1), 32'(want_done));
        checkOutput({tag, "_busy_len"}, 32'(busy_cnt), 32'(want_done - 1));
        checkOutput({tag, "_busy_at_done"}, 32'(o_busy), 32'd0);
        checkOutput({tag, "_mask"}, 32'(o_mask), 32'(want_mask));
        checkOutput({tag, "_match"}, 32'(o_match), 32'(want_match));
        checkOutput({tag, "_vec_max"}, 32'(o_vec), 32'hF);
`ifdef MINTERM_COUNT_EN
        checkOutput({tag, "_count"}, 32'(which ? cnt_b : cnt_a), 32'(want_count));
`else
        if (want_count < 0) $display("[TB] note: negative count request for %s", tag);
`endif
        @(posedge clk);
        #1;
        checkOutput({tag, "_done_pulse"}, 32'(o_done), 32'd0);
        checkOutput({tag, "_mask_hold"}, 32'(o_mask), 32'(want_mask));
        checkOutput({tag, "_match_hold"}, 32'(o_match), 32'(want_match));
    endtask

    initial begin
        // Reset state
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_busy", 32'(busy_a), 32'd0);
        checkOutput("rst_done", 32'(done_a), 32'd0);
        checkOutput("rst_mask", 32'(mask_a), 32'd0);
        checkOutput("rst_match", 32'(match_a), 32'd0);
        checkOutput("rst_vec", 32'(vec_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // f_in tied 0, expected 0: done in cycle 33, match
        applyStimulus("zero", 1'b0, 0, 16'h0000, 1'b0, 33, 16'h0000, 1'b1, 0);
        // f_in = d: alternating mask, off-by-one reference
        applyStimulus("dvar", 1'b0, 1, 16'hAAAB, 1'b0, 33, 16'hAAAA, 1'b0, 8);
        // Minimised function from its minterm list
        applyStimulus("func", 1'b0, 2, 16'h35A5, 1'b0, 33, 16'h35A5, 1'b1, 8);
        // SETTLE_CYCLES=0, f_in tied 1: done in cycle 17
        applyStimulus("fast", 1'b1, 3, 16'hFFFF, 1'b0, 17, 16'hFFFF, 1'b1, 16);
        // Restart attempt and reference change during the scan are ignored
        applyStimulus("rstrt", 1'b0, 1, 16'hAAAA, 1'b1, 33, 16'hAAAA, 1'b1, 8);

        // Asynchronous reset at cycle 10 of a scan
        sel   = 1'b0;
        fmode = 3;
        @(negedge clk);
        exp_a   = 16'hFFFF;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("midscan_mask", 32'(mask_a), 32'h001F);
        checkOutput("midscan_vec", 32'(vec_a), 32'd5);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_busy", 32'(busy_a), 32'd0);
        checkOutput("arst_mask", 32'(mask_a), 32'd0);
        checkOutput("arst_vec", 32'(vec_a), 32'd0);
        checkOutput("arst_match", 32'(match_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("arst_idle", 32'(busy_a), 32'd0);
        applyStimulus("after_rst", 1'b0, 2, 16'h35A5, 1'b0, 33, 16'h35A5, 1'b1, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
